// File: rtl/linear_step_interpolator_pkg.sv
// Shared stepper definitions: interpolator state encoding and width helpers.
`ifndef STEPPER_X_BITS
`define STEPPER_X_BITS 8
`endif
`ifndef STEPPER_Y_BITS
`define STEPPER_Y_BITS 8
`endif

package Stepper_p;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int max_bits(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/linear_step_interpolator_split.sv
// Splits a signed step count into unsigned magnitude and sign bit.
module StepMagnitudeSplit #(
  parameter int N = 8
) (
  input  logic [N-1:0] value,
  output logic [N-1:0] magnitude,
  output logic         sign
);

  // The most negative value wraps to 2^(N-1), which is exact as unsigned.
  assign sign      = value[N-1];
  assign magnitude = sign ? (~value + N'(1)) : value;

endmodule

// File: rtl/linear_step_interpolator.sv
// Bresenham two-axis step interpolator; one iteration per clk_en tick.
module linear_step_interpolator
  import Stepper_p::*;
#(
  parameter int STEPPER_X_BITS = `STEPPER_X_BITS,
  parameter int STEPPER_Y_BITS = `STEPPER_Y_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      trigger_in,
  input  logic [STEPPER_X_BITS-1:0] num_steps_x,
  input  logic [STEPPER_Y_BITS-1:0] num_steps_y,
  output logic                      pulse_x,
  output logic                      pulse_y,
  output logic                      dir_x,
  output logic                      dir_y,
  output logic                      done_out
);

  localparam int MB = max_bits(STEPPER_X_BITS, STEPPER_Y_BITS);
  localparam int EW = MB + 2;

  logic [STEPPER_X_BITS-1:0] mag_x;
  logic [STEPPER_Y_BITS-1:0] mag_y;
  logic                      sgn_x;
  logic                      sgn_y;

  StepMagnitudeSplit #(.N(STEPPER_X_BITS)) u_split_x (
    .value    (num_steps_x),
    .magnitude(mag_x),
    .sign     (sgn_x)
  );

  StepMagnitudeSplit #(.N(STEPPER_Y_BITS)) u_split_y (
    .value    (num_steps_y),
    .magnitude(mag_y),
    .sign     (sgn_y)
  );

  state_t               state;
  state_t               state_next;
  logic                 trig_q;
  logic                 start;
  logic                 active;
  logic                 tick;
  logic [MB-1:0]        dx;
  logic [MB-1:0]        dy;
  logic [MB-1:0]        rx;
  logic [MB-1:0]        ry;
  logic [MB-1:0]        mx;
  logic [MB-1:0]        my;
  logic signed [EW-1:0] err;
  logic signed [EW-1:0] err_n;
  logic signed [EW-1:0] dxe;
  logic signed [EW-1:0] dye;
  logic signed [EW:0]   e2;
  logic signed [EW:0]   pdx;
  logic signed [EW:0]   pdy;
  logic                 sx;
  logic                 sy;

  assign mx     = MB'(mag_x);
  assign my     = MB'(mag_y);
  assign start  = (state == IDLE) && trigger_in && !trig_q;
  assign active = (rx != '0) || (ry != '0);
  assign tick   = (state == RUN) && clk_en && active;

  assign dxe = $signed({2'b00, dx});
  assign dye = $signed({2'b00, dy});
  assign e2  = {err, 1'b0};
  assign pdx = $signed({3'b000, dx});
  assign pdy = $signed({3'b000, dy});
  assign sx  = (e2 > -pdy) && (rx != '0);
  assign sy  = (e2 < pdx) && (ry != '0);

  assign err_n = err + (sy ? dxe : '0) - (sx ? dye : '0);

  assign done_out = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (!active) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q  <= 1'b0;
      pulse_x <= 1'b0;
      pulse_y <= 1'b0;
      dir_x   <= 1'b0;
      dir_y   <= 1'b0;
      dx      <= '0;
      dy      <= '0;
      rx      <= '0;
      ry      <= '0;
      err     <= '0;
    end else begin
      trig_q  <= trigger_in;
      pulse_x <= tick && sx;
      pulse_y <= tick && sy;
      if (start) begin
        dir_x <= sgn_x;
        dir_y <= sgn_y;
        dx    <= mx;
        dy    <= my;
        rx    <= mx;
        ry    <= my;
        err   <= $signed({2'b00, mx}) - $signed({2'b00, my});
      end else if (tick) begin
        err <= err_n;
        if (sx) rx <= rx - MB'(1);
        if (sy) ry <= ry - MB'(1);
      end
    end
  end

endmodule

// File: tb/tb_linear_step_interpolator.sv
// Directed bench for linear_step_interpolator with a per-move plan model.
module tb_linear_step_interpolator;

  localparam int NX = 8;
  localparam int NY = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          trigger_in;
  logic [NX-1:0] num_steps_x;
  logic [NY-1:0] num_steps_y;
  logic          pulse_x;
  logic          pulse_y;
  logic          dir_x;
  logic          dir_y;
  logic          done_out;

  int vectors     = 0;
  int miscompares = 0;
  int en_period   = 2;
  int en_cnt      = 0;

  always #5 clk = ~clk;

  linear_step_interpolator #(
    .STEPPER_X_BITS(NX),
    .STEPPER_Y_BITS(NY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .trigger_in (trigger_in),
    .num_steps_x(num_steps_x),
    .num_steps_y(num_steps_y),
    .pulse_x    (pulse_x),
    .pulse_y    (pulse_y),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .done_out   (done_out)
  );

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a move is a precomputed list of per-tick (x,y) step decisions.
  bit armed = 1'b0;
  bit m_busy, m_prev;
  bit e_done, e_px, e_py, e_dx, e_dy;
  bit plan_x[$];
  bit plan_y[$];

  function automatic void build_plan(input int x, input int y);
    int ax, ay, err, rx, ry, e2;
    bit sx, sy;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    err = ax - ay;
    rx = ax;
    ry = ay;
    plan_x.delete();
    plan_y.delete();
    while (rx > 0 || ry > 0) begin
      e2 = 2 * err;
      sx = (e2 > -ay) && (rx > 0);
      sy = (e2 < ax) && (ry > 0);
      if (sy) err += ax;
      if (sx) err -= ay;
      if (sx) rx--;
      if (sy) ry--;
      plan_x.push_back(sx);
      plan_y.push_back(sy);
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      armed  = 1'b1;
      m_busy = 1'b0;
      m_prev = 1'b0;
      e_done = 1'b1;
      e_px   = 1'b0;
      e_py   = 1'b0;
      e_dx   = 1'b0;
      e_dy   = 1'b0;
      plan_x.delete();
      plan_y.delete();
    end else if (armed) begin
      e_px = 1'b0;
      e_py = 1'b0;
      if (!m_busy) begin
        if (trigger_in && !m_prev) begin
          m_busy = 1'b1;
          e_done = 1'b0;
          e_dx   = num_steps_x[NX-1];
          e_dy   = num_steps_y[NY-1];
          build_plan(int'($signed(num_steps_x)), int'($signed(num_steps_y)));
        end
      end else if (plan_x.size() == 0) begin
        m_busy = 1'b0;
        e_done = 1'b1;
      end else if (clk_en) begin
        e_px = plan_x.pop_front();
        e_py = plan_y.pop_front();
      end
      m_prev = trigger_in;
    end
    #1;
    if (armed) begin
      check("done_out", done_out, e_done);
      check("pulse_x", pulse_x, e_px);
      check("pulse_y", pulse_y, e_py);
      check("dir_x", dir_x, e_dx);
      check("dir_y", dir_y, e_dy);
    end
  end

  // Pulse log: one entry {pulse_x,pulse_y} per pulse cycle, i.e. per tick.
  bit [1:0] plog[$];

  always @(negedge clk) begin
    if (armed && (pulse_x || pulse_y)) plog.push_back({pulse_x, pulse_y});
  end

  function automatic int mask(input int b);
    int m = 0;
    foreach (plog[i]) if (plog[i][b]) m |= (1 << i);
    return m;
  endfunction

  function automatic int count(input int b);
    int c = 0;
    foreach (plog[i]) if (plog[i][b]) c++;
    return c;
  endfunction

  initial begin
    clk_en = 1'b0;
    forever begin
      @(negedge clk);
      en_cnt++;
      clk_en = (en_cnt % en_period) == 0;
    end
  end

  task automatic start_move(input int x, input int y);
    @(negedge clk);
    num_steps_x = x[NX-1:0];
    num_steps_y = y[NY-1:0];
    trigger_in  = 1'b1;
    @(negedge clk);
    trigger_in  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_out !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_int(tag, int'(n < budget), 1);
  endtask

  task automatic check_34(input string tag);
    check_int({tag, "_ticks"}, plog.size(), 4);
    check_int({tag, "_xmask"}, mask(1), 'b1101);
    check_int({tag, "_ymask"}, mask(0), 'b1111);
  endtask

  initial begin
    reset       = 1'b1;
    trigger_in  = 1'b0;
    num_steps_x = '0;
    num_steps_y = '0;
    repeat (2) @(negedge clk);
    check("rst_done", done_out, 1'b1);
    check("rst_px", pulse_x, 1'b0);
    check("rst_dirx", dir_x, 1'b0);
    reset = 1'b0;

    en_period = 2;
    plog.delete();
    start_move(3, -4);
    check("m34_dirx", dir_x, 1'b0);
    check("m34_diry", dir_y, 1'b1);
    wait_done(40, "m34_wait");
    check_34("m34");

    plog.delete();
    start_move(0, 0);
    check("zero_t1", done_out, 1'b0);
    @(negedge clk);
    check("zero_t2", done_out, 1'b1);
    check_int("zero_pulses", plog.size(), 0);

    plog.delete();
    start_move(-5, 0);
    check("m50_dirx", dir_x, 1'b1);
    wait_done(40, "m50_wait");
    check_int("m50_x", count(1), 5);
    check_int("m50_y", count(0), 0);

    plog.delete();
    start_move(0, 7);
    check("m07_dirx", dir_x, 1'b0);
    wait_done(40, "m07_wait");
    check_int("m07_x", count(1), 0);
    check_int("m07_y", count(0), 7);

    en_period = 1;
    plog.delete();
    start_move(-128, 31);
    wait_done(400, "ext1_wait");
    check_int("ext1_x", count(1), 128);
    check_int("ext1_y", count(0), 31);
    check_int("ext1_ticks", plog.size(), 128);

    plog.delete();
    start_move(127, -32);
    wait_done(400, "ext2_wait");
    check_int("ext2_x", count(1), 127);
    check_int("ext2_y", count(0), 32);

    en_period = 2;
    plog.delete();
    start_move(3, -4);
    begin
      int n = 0;
      while (plog.size() < 2 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_int("mid_wait", int'(n < 40), 1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_done", done_out, 1'b1);
    check("mid_px", pulse_x, 1'b0);
    check("mid_py", pulse_y, 1'b0);
    check("mid_diry", dir_y, 1'b0);
    plog.delete();
    start_move(3, -4);
    wait_done(40, "post_wait");
    check_34("post");

    plog.delete();
    start_move(3, -4);
    repeat (2) @(negedge clk);
    trigger_in = 1'b1;
    wait_done(40, "hold_wait");
    repeat (10) @(negedge clk);
    check_34("hold");
    check("hold_done", done_out, 1'b1);
    trigger_in = 1'b0;
    @(negedge clk);
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    wait_done(40, "again_wait");
    repeat (4) @(negedge clk);
    check_int("again_ticks", plog.size(), 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
